// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32I/RV64I immediate generator with a two-entry skid buffer.
// Rev 1.0
`default_nettype none

module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [2:0]       ImmSrc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  ImmOp_o,
  output logic [2:0]       imm_type_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam logic [2:0] T_I   = 3'd0;
  localparam logic [2:0] T_S   = 3'd1;
  localparam logic [2:0] T_B   = 3'd2;
  localparam logic [2:0] T_J   = 3'd3;
  localparam logic [2:0] T_U   = 3'd4;
  localparam logic [2:0] T_Z   = 3'd5;
  localparam logic [2:0] T_SH  = 3'd6;
  localparam logic [2:0] T_BAD = 3'd7;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [2:0]      dec_type;
  logic [2:0]      sel_type;
  logic [XLEN-1:0] shamt;
  logic [XLEN-1:0] imm;
  logic            new_ill;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];

  always_comb begin
    dec_type = T_BAD;
    case (opc)
      7'b0000011, 7'b1100111: dec_type = T_I;
      7'b0010011:             dec_type = (f3 == 3'b001 || f3 == 3'b101) ? T_SH : T_I;
      7'b0011011: begin
        // The W-form shift/arith opcode only exists on RV64.
        if (XLEN == 64) dec_type = (f3 == 3'b001 || f3 == 3'b101) ? T_SH : T_I;
        else            dec_type = T_BAD;
      end
      7'b0100011:             dec_type = T_S;
      7'b1100011:             dec_type = T_B;
      7'b1101111:             dec_type = T_J;
      7'b0110111, 7'b0010111: dec_type = T_U;
      7'b1110011:             dec_type = f3[2] ? T_Z : T_I;
      default:                dec_type = T_BAD;
    endcase
  end

  assign sel_type = AUTO_DECODE ? dec_type : ImmSrc_i;
  assign new_ill  = (sel_type == T_BAD);

  generate
    if (XLEN == 64) begin : g_shamt64
      assign shamt = {{(XLEN-6){1'b0}}, instr_i[25:20]};
    end else begin : g_shamt32
      assign shamt = {{(XLEN-5){1'b0}}, instr_i[24:20]};
    end
  endgenerate

  always_comb begin
    imm = '0;
    case (sel_type)
      T_I:  imm = {{(XLEN-11){instr_i[31]}}, instr_i[30:20]};
      T_S:  imm = {{(XLEN-11){instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
      T_B:  imm = {{(XLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      T_J:  imm = {{(XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      T_U:  imm = {{(XLEN-31){instr_i[31]}}, instr_i[30:12], 12'b0};
      T_Z:  imm = {{(XLEN-5){1'b0}}, instr_i[19:15]};
      T_SH: imm = shamt;
      default: imm = '0;
    endcase
  end

  logic [XLEN-1:0]  out_imm, skid_imm;
  logic [2:0]       out_type, skid_type;
  logic             out_ill, skid_ill;
  logic             out_vld, skid_vld;
  logic [CNT_W-1:0] ill_cnt;
  logic             accept;
  logic             drain;

  // Ready depends only on skid occupancy, so it never combinationally follows out_ready_i.
  assign in_ready_o = !skid_vld;
  assign accept     = in_valid_i && !skid_vld;
  assign drain      = out_vld && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_imm   <= '0;
      out_type  <= '0;
      out_ill   <= 1'b0;
      out_vld   <= 1'b0;
      skid_imm  <= '0;
      skid_type <= '0;
      skid_ill  <= 1'b0;
      skid_vld  <= 1'b0;
    end else if (skid_vld) begin
      if (drain) begin
        out_imm  <= skid_imm;
        out_type <= skid_type;
        out_ill  <= skid_ill;
        skid_vld <= 1'b0;
      end
    end else if (accept) begin
      if (!out_vld || drain) begin
        out_imm  <= imm;
        out_type <= sel_type;
        out_ill  <= new_ill;
        out_vld  <= 1'b1;
      end else begin
        skid_imm  <= imm;
        skid_type <= sel_type;
        skid_ill  <= new_ill;
        skid_vld  <= 1'b1;
      end
    end else if (drain) begin
      out_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ill_cnt <= '0;
    end else if (accept && new_ill && (ill_cnt != {CNT_W{1'b1}})) begin
      ill_cnt <= ill_cnt + 1'b1;
    end
  end

  assign out_valid_o   = out_vld;
  assign ImmOp_o       = out_imm;
  assign imm_type_o    = out_type;
  assign illegal_o     = out_ill;
  assign illegal_cnt_o = ill_cnt;

endmodule

`default_nettype wire
